// File: rtl/inv_chain_pkg.sv
// Shared types and helpers for the inverter-chain pulse tester.
// Holds the FSM state encoding, the default drain length and the expected edge count.
package inv_chain_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HIGH  = 3'd1,
    LOW   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int DEFAULT_DRAIN_CYCLES = 4;
  localparam int MAX_CNT_W            = 32;

  // Every pulse that survives the chain contributes one rising and one falling edge.
  function automatic logic [MAX_CNT_W:0] expected_edges(input logic [MAX_CNT_W-1:0] pulses);
    return {pulses, 1'b0};
  endfunction

endpackage

// File: rtl/INV_X1.sv
// Behavioural model of the single-drive library inverter used to build the chain.
module INV_X1 (
  input  logic I,
  output logic ZN
);

  assign ZN = ~I;

endmodule

// File: rtl/inv_chain_n.sv
// Purely combinational chain of STAGES INV_X1 cells under test.
module inv_chain_n #(
  parameter int STAGES = 26
) (
  input  logic myin,
  output logic myout
);

  logic [STAGES:0] node;

  assign node[0] = myin;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    INV_X1 u_inv (
      .I  (node[i]),
      .ZN (node[i+1])
    );
  end

  assign myout = node[STAGES];

endmodule

// File: rtl/inv_chain_pulse_tester.sv
// Drives pulse trains into an inverter chain, resynchronises its output and
// counts edges, flagging runs where the edge count differs from 2*pulse_count.
module inv_chain_pulse_tester
  import inv_chain_pkg::*;
#(
  parameter int STAGES       = 26,
  parameter int PW_W         = 8,
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PW_W-1:0]  pulse_width,
  input  logic [PW_W-1:0]  gap_width,
  input  logic [CNT_W-1:0] pulse_count,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edges_seen,
  output logic             mismatch,
  output logic             chain_in,
  output logic             chain_out_sync
);

  // The phase timer also times DRAIN, so it must hold the larger of the two ranges.
  localparam int DW    = $clog2(DRAIN_CYCLES) + 1;
  localparam int TMR_W = (PW_W > DW) ? PW_W : DW;
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_nx;
  logic             timer_zero;
  logic             accept;
  logic [PW_W-1:0]  p_start;
  logic [PW_W-1:0]  g_start;
  logic [PW_W-1:0]  p_len;
  logic [PW_W-1:0]  g_len;
  logic [CNT_W-1:0] n_total;
  logic [CNT_W-1:0] pulses_left;
  logic [CNT_W:0]   exp_edges;
  logic             chain_raw;
  logic             sync1;
  logic             prev;
  logic             edge_det;
  logic             count_en;

  inv_chain_n #(
    .STAGES (STAGES)
  ) u_chain (
    .myin  (chain_in),
    .myout (chain_raw)
  );

  assign timer_zero = (timer == {TMR_W{1'b0}});
  assign accept     = (state == IDLE) && start;
  assign p_start    = (pulse_width == {PW_W{1'b0}}) ? PW_W'(1'b1) : pulse_width;
  assign g_start    = (gap_width == {PW_W{1'b0}}) ? PW_W'(1'b1) : gap_width;
  assign exp_edges  = (CNT_W+1)'(expected_edges(MAX_CNT_W'(n_total)));
  assign edge_det   = chain_out_sync ^ prev;
  assign count_en   = (state == HIGH) || (state == LOW) || (state == DRAIN);

  // Next-state and phase-timer reload; the timer holds the remaining cycles minus one.
  always_comb begin
    state_nx = state;
    timer_nx = timer_zero ? timer : (timer - TMR_W'(1'b1));
    case (state)
      IDLE: begin
        if (start) begin
          if (pulse_count != {CNT_W{1'b0}}) begin
            state_nx = HIGH;
            timer_nx = TMR_W'(p_start) - TMR_W'(1'b1);
          end else begin
            state_nx = DRAIN;
            timer_nx = DRAIN_LOAD;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      HIGH: begin
        if (timer_zero) begin
          state_nx = LOW;
          timer_nx = TMR_W'(g_len) - TMR_W'(1'b1);
        end else begin
          state_nx = HIGH;
        end
      end
      LOW: begin
        if (timer_zero) begin
          if (pulses_left == CNT_W'(1'b1)) begin
            state_nx = DRAIN;
            timer_nx = DRAIN_LOAD;
          end else begin
            state_nx = HIGH;
            timer_nx = TMR_W'(p_len) - TMR_W'(1'b1);
          end
        end else begin
          state_nx = LOW;
        end
      end
      DRAIN: begin
        if (timer_zero) begin
          state_nx = DONE;
        end else begin
          state_nx = DRAIN;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        timer_nx = {TMR_W{1'b0}};
      end
    endcase
  end

  // State, timer and registered drive/status outputs (one cycle behind the state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= {TMR_W{1'b0}};
      chain_in <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      timer    <= timer_nx;
      chain_in <= (state == HIGH);
      busy     <= count_en;
      done     <= (state == DONE);
    end
  end

  // Operand latches and remaining-pulse counter, frozen for the whole run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_len       <= PW_W'(1'b1);
      g_len       <= PW_W'(1'b1);
      n_total     <= {CNT_W{1'b0}};
      pulses_left <= {CNT_W{1'b0}};
    end else if (accept) begin
      p_len       <= p_start;
      g_len       <= g_start;
      n_total     <= pulse_count;
      pulses_left <= pulse_count;
    end else if ((state == LOW) && timer_zero) begin
      pulses_left <= pulses_left - CNT_W'(1'b1);
    end
  end

  // Two-flop synchroniser for the chain output plus the previous-value flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1          <= 1'b0;
      chain_out_sync <= 1'b0;
      prev           <= 1'b0;
    end else begin
      sync1          <= chain_raw;
      chain_out_sync <= sync1;
      prev           <= chain_out_sync;
    end
  end

  // Saturating edge counter and result flag; IDLE edges (e.g. odd-chain settling) are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      edges_seen <= {CNT_W{1'b0}};
      mismatch   <= 1'b0;
    end else if (accept) begin
      edges_seen <= {CNT_W{1'b0}};
      mismatch   <= 1'b0;
    end else begin
      if (count_en && edge_det && (edges_seen != {CNT_W{1'b1}})) begin
        edges_seen <= edges_seen + CNT_W'(1'b1);
      end
      if (state == DONE) begin
        mismatch <= ({1'b0, edges_seen} != exp_edges);
      end
    end
  end

endmodule

// File: doc/inv_chain_pulse_tester.md
# inv_chain_pulse_tester

Self-checking pulse-propagation tester for delay-model evaluation. Drives programmable trains of pulses into a parametrised chain of INV_X1 cells, samples the chain output back into the clock domain and counts edges. It flags any pulse lost or split in the chain. It sits between the characterisation controller and the inverter chain under test.

## Interface
Parameters:
- STAGES, 26: number of INV_X1 stages in the chain, at least 1; an odd value inverts the chain.
- PW_W, 8: width of the pulse-width and gap-width fields.
- CNT_W, 16: width of the pulse-count and edge-count fields.
- DRAIN_CYCLES, 4: settle cycles after the last pulse, at least 3.

Ports:
- clk, in, 1: sole clock.
- rst_n, in, 1: reset, synchronous and active-low.
- start, in, 1: launch a test; sampled only in IDLE.
- pulse_width, in, PW_W: high-phase length in cycles, sampled at start; 0 is treated as 1.
- gap_width, in, PW_W: low-phase length in cycles, sampled at start; 0 is treated as 1.
- pulse_count, in, CNT_W: number of pulses, sampled at start.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse when results are valid.
- edges_seen, out, CNT_W: edges counted at the synchronised chain output; saturates at all-ones.
- mismatch, out, 1: edges_seen differs from 2*pulse_count.
- chain_in, out, 1: registered chain drive, for observation.
- chain_out_sync, out, 1: synchronised chain output.

## Operation
- States:
  - IDLE
  - HIGH: chain_in=1
  - LOW: chain_in=0
  - DRAIN
  - DONE
- IDLE→HIGH when start=1 and pulse_count≠0.
- IDLE→DRAIN when start=1 and pulse_count=0.
- HIGH→LOW after max(pulse_width,1) cycles.
- LOW→HIGH after max(gap_width,1) cycles while pulses remain.
- LOW→DRAIN after the last pulse.
- DRAIN→DONE after DRAIN_CYCLES cycles.
- DONE→IDLE unconditionally.
- Operands are latched at start, so input changes mid-run have no effect.
- start while busy is ignored.
- Accepting a start clears edges_seen and mismatch.
- Chain output path: a 2-flop synchroniser, then a previous-value flop. An edge is any difference between the synchronised value and the previous value.
- Edges are counted in HIGH, LOW and DRAIN only. In IDLE the synchroniser still runs, but edges are not counted.
- Counting saturates at 2^CNT_W−1.
- The expected count is 2*pulse_count, computed at CNT_W+1 bits so it cannot overflow.
- mismatch updates in DONE and holds until the next accepted start.
- Reset values: state=IDLE, chain_in=0, busy=0, done=0, edges_seen=0, mismatch=0, both synchroniser flops=0, previous-value flop=0.
- If STAGES is odd, the chain output sits at 1 after reset. The first synchroniser edges after reset fall in IDLE and are not counted.
- Reset mid-operation: on the next clk edge, chain_in=0 and all state and outputs return to their reset values. No done is issued.

## Timing
- Accepted start at edge k: chain_in=1 and busy=1 from edge k+1.
- Pulse i rises at k+1+i*(P+G), where P=max(pulse_width,1) and G=max(gap_width,1).
- The chain is combinational, with delay below one clk period.
- A chain_in change is visible on chain_out_sync 2 cycles later and is counted on the 3rd cycle.
- DRAIN_CYCLES ≥ 3 guarantees the final falling edge is counted.
- done asserts at edge k+1+N*(P+G)+DRAIN_CYCLES, where N=pulse_count.
- busy falls in the same cycle done rises.
- Back-to-back: a start in the cycle after done is accepted.

## Structure
- Package inv_chain_pkg holds:
  - the state enum (IDLE, HIGH, LOW, DRAIN, DONE);
  - the default DRAIN_CYCLES constant;
  - a function computing the expected edge count.
- Sub-module inv_chain_n holds the chain: STAGES generate-instantiated INV_X1 cells (pins I/ZN), ports myin/myout, with no sequential logic.
- Tester top holds the FSM, phase counter, pulse counter, synchroniser and edge counter.

## Test plan
- Reset, then start with pulse_width=3, gap_width=2, pulse_count=4 → done at cycle 1+20+4. edges_seen=8, mismatch=0, chain_in pattern 111 00 repeated 4 times.
- pulse_count=0 → done 1+DRAIN_CYCLES cycles after start, edges_seen=0, mismatch=0, chain_in stays 0.
- pulse_width=0, gap_width=0, pulse_count=5 → behaves as 1/1: chain_in toggles every cycle, edges_seen=10.
- Assert rst_n=0 for one cycle mid-HIGH → chain_in=0 and busy=0 next cycle, no done. A new start (pulse_count=2) then yields edges_seen=4.
- Force the chain output stuck for one pulse (bench force) with pulse_count=3 → edges_seen=4, mismatch=1. Pulse start during busy → ignored, run length unchanged.
- CNT_W=4, pulse_count=10 → edges_seen saturates at 15, mismatch=1. Repeat for STAGES=1 and STAGES=25 → odd chains pass with mismatch=0.
